c7bbiu_rd: RTL
==============

Name: c7bbiu_rd

Overview:
Read-side bus interface unit directly downstream of the instruction cache controller. It accepts linefill and single-beat read requests on the icu_biu_* interface and issues them as AXI4 read transactions (AR/R channels, 64-bit data). It returns beats to the cache as data_valid pulses, with data_last and fault marking the final beat. Only one transaction is outstanding at a time.

Parameters:
AXI_ID, 4'h0, constant arid driven on every request.
LINE_BEATS, 4, beats per linefill. arlen = LINE_BEATS-1; legal values are 2, 4 and 8.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
icu_biu_req  in  1  read request from the cache; sampled only in IDLE.
icu_biu_addr  in  29  [31:3] 8-byte-aligned start address.
icu_biu_single  in  1  1 = single 64-bit beat, 0 = linefill of LINE_BEATS beats.
biu_icu_ack  out  1  one-cycle pulse: request accepted by the bus (AR handshake).
biu_icu_data_valid  out  1  beat valid this cycle.
biu_icu_data_last  out  1  final beat of the transaction; coincides with data_valid.
biu_icu_data  out  64  beat data; all zeros when data_valid = 0.
biu_icu_fault  out  1  error on the transaction; valid only with data_last.
axi_arvalid  out  1  AR valid.
axi_arready  in  1  AR ready.
axi_araddr  out  32  {addr[31:3], 3'b000}.
axi_arid  out  4  AXI_ID.
axi_arlen  out  8  0 if single, else LINE_BEATS-1.
axi_arsize  out  3  3'b011 (8 bytes).
axi_arburst  out  2  2'b01 (INCR).
axi_rvalid  in  1  R valid.
axi_rready  out  1  R ready.
axi_rdata  in  64  R data.
axi_rresp  in  2  R response; bit 1 set = SLVERR/DECERR.
axi_rlast  in  1  R last.

Behaviour:
- Reset values: state = IDLE. axi_arvalid, axi_rready, ack, data_valid, data_last and fault are all 0. biu_icu_data = 0. Beat counter and error flag = 0. Reset taken in any state aborts the transaction immediately with no further outputs. Bus-side recovery is the system reset's job.
- FSM states: IDLE, ADDR, DATA.
- IDLE -> ADDR when icu_biu_req = 1. On that edge, latch addr, single and arlen, and clear the beat counter and error flag. While in IDLE, axi_arvalid = 0 and axi_rready = 0.
- ADDR:
  - axi_arvalid = 1, driven from the state register, so it rises the cycle after req is sampled.
  - AR fields are stable from the latched registers and must not change while arvalid = 1 and arready = 0.
  - When axi_arvalid & axi_arready: biu_icu_ack = 1 that same cycle (combinational), next state = DATA.
- icu_biu_req is ignored outside IDLE. The cache holds req until the cycle after ack, and that must not start a second transaction.
- DATA:
  - axi_rready = 1.
  - A beat is axi_rvalid & axi_rready.
  - On a beat: data_valid = 1 and biu_icu_data = axi_rdata, both combinational and in the same cycle. The cache consumes the final beat unregistered.
  - The beat counter increments per beat.
  - The error flag ORs in axi_rresp[1].
  - Gaps in rvalid produce no output.
- Termination: final = (cnt == latched arlen) | axi_rlast. On the final beat:
  - data_last = 1.
  - fault = error flag | rresp[1] | (rlast != (cnt == arlen)), i.e. an early or late rlast is a protocol fault.
  - Next state = IDLE.
- Latency: req sampled at cycle T; arvalid at T+1; ack at the first cycle ≥ T+1 with arready = 1. The first data beat can appear no earlier than the cycle after ack.
- Back-to-back: a new req can be sampled in the cycle after data_last. There is no idle bubble beyond that.
- biu_icu_fault and data_last are never asserted without data_valid.

Test Plan:
- Linefill, single = 0, addr 0x0000_1000>>3. arready held low 2 cycles, then R beats 0x11..,0x22..,0x33..,0x44.. back-to-back with rlast on beat 4 -> araddr = 0x0000_1000, arlen = 3, ack exactly one pulse in the arready cycle, 4 data_valid pulses in order, data_last + data 0x44.. together on beat 4, fault = 0, FSM back in IDLE.
- Single read, addr 0x8000_0008: one beat 0xDEAD_BEEF_0123_4567 with rlast = 1 -> arlen = 0, one data_valid with data_last, matching data, fault = 0.
- Linefill with rresp = 2'b10 on beat 2 only, plus one-cycle rvalid gaps between beats -> 4 data_valid pulses with no output in the gaps, fault = 1 only on beat 4 with data_last.
- Linefill with rlast asserted on beat 3 -> data_last + fault on beat 3, return to IDLE, beat 4 never accepted (rready = 0).
- Reset asserted after beat 2 of a linefill -> next cycle all outputs 0, IDLE. A fresh req after reset produces a correct new transaction.
- req held high through ack + 1 cycle, then a second req in the cycle after data_last -> exactly one AR for the first request, second arvalid the cycle after the second req is sampled.

Source files
------------

// File: rtl/c7bbiu_rd.sv
// Read-side bus interface: turns instruction-cache linefill/single requests
// into single-outstanding AXI4 read bursts and streams the beats back.
module c7bbiu_rd #(
    parameter logic [3:0]  AXI_ID     = 4'h0,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        icu_biu_req,
    input  logic [28:0] icu_biu_addr,
    input  logic        icu_biu_single,
    output logic        biu_icu_ack,
    output logic        biu_icu_data_valid,
    output logic        biu_icu_data_last,
    output logic [63:0] biu_icu_data,
    output logic        biu_icu_fault,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [31:0] axi_araddr,
    output logic [3:0]  axi_arid,
    output logic [7:0]  axi_arlen,
    output logic [2:0]  axi_arsize,
    output logic [1:0]  axi_arburst,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    input  logic [63:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rlast
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

    state_t      state_q, state_d;
    logic [28:0] addr_q, addr_d;
    logic        single_q, single_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        beat;
    logic        cnt_done;
    logic        unused_rresp0;

    assign unused_rresp0 = axi_rresp[0];

    // AR fields come only from latched registers so they hold while stalled.
    assign axi_araddr  = {addr_q, 3'b000};
    assign axi_arid    = AXI_ID;
    assign axi_arlen   = arlen_q;
    assign axi_arsize  = 3'b011;
    assign axi_arburst = 2'b01;

    assign cnt_done = (cnt_q == arlen_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            single_q <= 1'b0;
            arlen_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            single_q <= single_d;
            arlen_q  <= arlen_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        single_d           = single_q;
        arlen_d            = arlen_q;
        cnt_d              = cnt_q;
        err_d              = err_q;
        beat               = 1'b0;
        axi_arvalid        = 1'b0;
        axi_rready         = 1'b0;
        biu_icu_ack        = 1'b0;
        biu_icu_data_valid = 1'b0;
        biu_icu_data_last  = 1'b0;
        biu_icu_data       = '0;
        biu_icu_fault      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (icu_biu_req) begin
                    addr_d   = icu_biu_addr;
                    single_d = icu_biu_single;
                    arlen_d  = icu_biu_single ? 8'd0 : LINE_LEN;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    biu_icu_ack = 1'b1;
                    state_d     = DATA;
                end
            end
            DATA: begin
                axi_rready = 1'b1;
                beat       = axi_rvalid;
                if (beat) begin
                    biu_icu_data_valid = 1'b1;
                    biu_icu_data       = axi_rdata;
                    cnt_d              = cnt_q + 8'd1;
                    err_d              = err_q | axi_rresp[1];
                    // Either side ending the burst terminates it; disagreement is a fault.
                    if (cnt_done || axi_rlast) begin
                        biu_icu_data_last = 1'b1;
                        biu_icu_fault     = err_q | axi_rresp[1] | (axi_rlast != cnt_done);
                        state_d           = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
